// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: registered x/y, video_on, syncs and strobes.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_scan_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        pix_stb,
`ifdef VGA_FRAME_CNT_EN
   output logic        frame_start,
   output logic [15:0] frame_cnt
`else
   output logic        frame_start
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0]   H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0]   V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0]   HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0]   VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          SP       = 1'(SYNC_POL);

   logic [DW-1:0] div;
   logic [10:0]   hcnt;
   logic [10:0]   vcnt;
   logic          pix_en;
   logic          h_end;
   logic          v_end;
   logic          hs_on;
   logic          vs_on;
   logic          origin;

   assign pix_en = (div == DIV_LAST);
   assign h_end  = (hcnt == H_LAST);
   assign v_end  = (vcnt == V_LAST);
   assign hs_on  = (hcnt >= HS_BEG) && (hcnt < HS_END);
   assign vs_on  = (vcnt >= VS_BEG) && (vcnt < VS_END);
   assign origin = (hcnt == 11'd0) && (vcnt == 11'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div  <= '0;
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         div <= pix_en ? '0 : div + DW'(1);
         if (pix_en) begin
            if (h_end) begin
               hcnt <= '0;
               vcnt <= v_end ? '0 : vcnt + 11'd1;
            end else begin
               hcnt <= hcnt + 11'd1;
            end
         end
      end
   end

   // Outputs register the pre-increment counters so all flags describe x/y.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x           <= '0;
         y           <= '0;
         video_on    <= 1'b0;
         hsync       <= ~SP;
         vsync       <= ~SP;
         pix_stb     <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         x           <= hcnt;
         y           <= vcnt;
         video_on    <= (hcnt < H_VIS) && (vcnt < V_VIS);
         hsync       <= hs_on ? SP : ~SP;
         vsync       <= vs_on ? SP : ~SP;
         pix_stb     <= 1'b1;
         frame_start <= origin;
      end else begin
         pix_stb     <= 1'b0;
         frame_start <= 1'b0;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (pix_en && origin) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster timing generator for the VGA paint path.
- Produces the 11-bit pixel coordinates x, y that feed the shape hit-test stages (parallelogram, rectangle, and the other paint blocks), plus a video-active flag and the hsync/vsync pins.
- All outputs are registered and mutually aligned, so downstream hit logic and the colour mux see a consistent pixel in the same clk cycle.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (>=1); 50 MHz clk gives a 25 MHz pixel rate.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- x  out  11  horizontal pixel coordinate
- y  out  11  vertical pixel coordinate
- video_on  out  1  high while (x, y) is inside the visible area
- hsync  out  1  horizontal sync pin
- vsync  out  1  vertical sync pin
- pix_stb  out  1  one-clk strobe, high in the cycle x/y/flags take a new value
- frame_start  out  1  one-clk strobe, high in the cycle (x, y) becomes (0, 0)

Behaviour:
- Interface: single clock clk. Reset rst is asynchronous and active-low; asserting it takes effect immediately regardless of clk.
- Reset values: div=0, hcnt=0, vcnt=0, x=0, y=0, video_on=0, pix_stb=0, frame_start=0, hsync=vsync=~SYNC_POL (deasserted).
- Reset mid-frame: everything returns to the reset values at once. No partial line or frame is completed.
- Pixel enable: div counts 0..CLK_DIV-1 and wraps. pix_en = (div==CLK_DIV-1). With CLK_DIV=1, pix_en is constantly 1.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - On each pix_en edge, hcnt increments. At H_TOTAL-1 it wraps to 0 and vcnt increments.
  - At vcnt=V_TOTAL-1 with hcnt=H_TOTAL-1, both wrap to 0.
- Output register:
  - On each pix_en edge the outputs load from the pre-increment counter values: x<=hcnt, y<=vcnt.
  - video_on <= (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
  - hsync <= SYNC_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - vsync follows the same rule on vcnt using the V_* parameters. vsync is level-based on vcnt for the whole line, not gated by hcnt.
  - frame_start <= (hcnt==0 && vcnt==0).
  - pix_stb <= 1.
  - On non-pix_en edges, all outputs hold except pix_stb<=0 and frame_start<=0.
- Latency:
  - The first pix_en edge after reset release is the CLK_DIV-th rising edge.
  - At that edge x=0, y=0, video_on=1, frame_start=1, pix_stb=1.
  - Outputs then change every CLK_DIV clk cycles.
- Widths: all counters are 11 bits. Parameter totals must be <= 2047 (not checked in RTL). Comparisons are unsigned.
- Downstream contract: x, y, video_on, hsync and vsync are mutually consistent in every cycle. Consumers qualify hit results with video_on.

Optional Feature:
- VGA_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt (out, 16 bits), reset 0.
  - frame_cnt increments on the same edge frame_start is set, wrapping 0xFFFF->0. The first frame after reset therefore reads 1.
  - Used to animate shape positions (cx/cy) without a separate timer.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset and first pixel: hold rst=0 for 5 clk, then release. Expect all outputs at reset values until the 2nd rising edge (CLK_DIV=2). At that edge expect x=0, y=0, video_on=1, frame_start=1, pix_stb=1 for one clk.
- Line timing on line 0:
  - video_on drops when x goes 639->640.
  - hsync low exactly for x=656..751 (96 pixels).
  - x wraps 799->0 with y 0->1.
  - pix_stb period is 2 clk throughout.
- Frame timing:
  - video_on stays 0 for y=480..524.
  - vsync low for y=490..491 across all x.
  - After (799, 524), the next pixel is (0, 0) with frame_start=1.
  - Frame period is 800*525*2 = 840000 clk.
- Async reset mid-frame: at (x=300, y=200), pulse rst low between clk edges. Expect outputs to go to reset values immediately, before the next edge, then restart as in the first-pixel scenario.
- CLK_DIV=1 build: expect pix_stb constantly 1 after the first edge, x incrementing every clk, and the first frame_start on the 1st edge after reset release.
- VGA_FRAME_CNT_EN defined: run 3 frames. Expect frame_cnt = 1, 2, 3, each change coincident with frame_start. Force the count to 0xFFFF and expect it to wrap to 0 at the next frame.
